// File: rtl/mod_write_buffer.sv
// Posted-write FIFO between the write-through cache and the SRAM data port.
// Writes are drained in order, one per de/rdy handshake, with a one-cycle
// de gap between accesses; rd_hazard flags a pending write to rd_addr.
module mod_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  output logic             wr_full,
  input  logic [31:0]      rd_addr,
  output logic             rd_hazard,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             sram_de,
  output logic             sram_drw,
  output logic [31:0]      sram_daddr,
  output logic [31:0]      sram_din,
  input  logic             sram_rdy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    GAP  = 2'b10
  } state_t;

  state_t             state;
  logic [AW-1:0]      addr_mem [DEPTH];
  logic [DW-1:0]      data_mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [DEPTH-1:0]   hit;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;

  // Full is refused even when a pop lands in the same cycle.
  assign wr_full = (count == CW'(DEPTH));
  assign push    = wr_req && !wr_full;
  assign pop     = (state == BUSY) && sram_rdy;

  // Payload storage; contents need no reset since valid bits qualify them.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= wr_addr;
      data_mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + PTR_W'(1);
        valid[wr_ptr]  <= 1'b1;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        valid[rd_ptr]  <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM: request, wait for rdy, then one idle cycle of de low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sram_de <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state   <= BUSY;
            sram_de <= 1'b1;
          end
        end
        BUSY: begin
          if (sram_rdy) begin
            state   <= GAP;
            sram_de <= 1'b0;
          end
        end
        GAP: begin
          state   <= IDLE;
          sram_de <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          sram_de <= 1'b0;
        end
      endcase
    end
  end

  // Per-entry address match against the pending read miss.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign hit[g] = valid[g] && (addr_mem[g] == rd_addr);
  end

  assign rd_hazard  = |hit;
  assign empty      = (count == '0) && (state == IDLE);
  assign sram_drw   = 1'b1;
  assign sram_daddr = addr_mem[rd_ptr];
  assign sram_din   = data_mem[rd_ptr];

endmodule

// File: doc/mod_write_buffer.md
Name: mod_write_buffer

Overview:
- Posted-write FIFO between the write-through cache hierarchy and the SRAM controller's data port.
- Data writes are queued, so the CPU stalls only when the buffer is full.
- The buffer drains entries to SRAM in order, one at a time, using the controller's de/rdy handshake.
- It flags read-after-write hazards so a data read miss waits until any pending write to the same address has reached SRAM.

Parameters:
- DEPTH, 4, number of buffered writes; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); width of the read/write pointers.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low.
- wr_req  input  1  cache requests to enqueue a write this cycle.
- wr_addr  input  32  byte address of the write.
- wr_data  input  32  write data.
- wr_full  output  1  buffer full; wr_req is ignored this cycle (cache stalls CPU).
- rd_addr  input  32  address of the pending data read miss.
- rd_hazard  output  1  some valid entry has address == rd_addr (combinational).
- empty  output  1  no valid entries and SRAM port idle.
- count  output  PTR_W+1  number of valid entries.
- sram_de  output  1  data-port request to the SRAM controller.
- sram_drw  output  1  data-port direction; constant 1 (write).
- sram_daddr  output  32  head-entry address.
- sram_din  output  32  head-entry data.
- sram_rdy  input  1  one-cycle pulse from the SRAM controller: access complete.

Behaviour:
- Reset (rst=0, asynchronous):
  - head/tail pointers, count and entry valid bits clear; FSM goes to IDLE.
  - sram_de=0, wr_full=0, empty=1, rd_hazard=0.
  - Reset mid-drain discards all entries, including the one in flight; sram_de drops immediately.
- Storage: circular array of DEPTH entries {addr[31:0], data[31:0]}; pointers wrap modulo DEPTH.
- count is a registered value, 0..DEPTH.
- wr_full = (count == DEPTH), combinational from count.
- Enqueue:
  - Accepted when wr_req && !wr_full; entry written at tail, tail++ on posedge.
  - Accepted write is visible at the head no earlier than the next cycle.
- Push refusal: while full, a push is refused even if a pop happens in the same cycle; the cache retries next cycle.
- Simultaneous accepted push and pop: count is unchanged; both pointers advance.
- FSM states: IDLE(00), BUSY(01), GAP(10).
  - IDLE: sram_de=0. If count != 0, go to BUSY next cycle.
  - BUSY: sram_de=1; sram_daddr/sram_din driven from the head entry and held stable.
    - On sram_rdy=1: pop head (head++, count--) and go to GAP.
    - Otherwise stay in BUSY indefinitely; there is no timeout.
  - GAP: sram_de=0 for exactly one cycle so the controller sees de deasserted between accesses; then IDLE.
  - Minimum spacing is one write per 3 cycles plus the SRAM latency.
  - sram_rdy outside BUSY is ignored.
- sram_drw = 1 always. sram_daddr/sram_din equal the head entry in every state; they are don't-care when empty.
- rd_hazard:
  - OR over valid entries of (entry.addr == rd_addr); full 32-bit compare.
  - Includes the in-flight head until its pop.
  - Excludes a write being accepted in the same cycle. The cache does not issue a read miss and a write in the same cycle.
- empty = (count == 0) && state == IDLE.
- Ordering: strict FIFO; duplicate addresses are not merged.
- Cache usage: flushing before an uncached access or VGA frame swap means waiting for empty=1.

Test Plan:
- Reset then idle: rst low 2 cycles, release → empty=1, count=0, sram_de=0, wr_full=0 for 10 cycles.
- Single write: wr_req with addr 0x00000010, data 0xDEADBEEF → next cycle sram_de=1 with those values; sram_rdy pulse 3 cycles later → count=0, sram_de=0 (GAP), empty=1 the cycle after.
- Fill and overflow (DEPTH=4):
  - Push 5 writes back-to-back while holding sram_rdy=0 → wr_full=1 after the 4th push; the 5th is dropped.
  - Release rdy pulses → SRAM sees addresses 0x0,0x4,0x8,0xC in order; the 5th address is never issued.
- Push during pop: with count=2 and sram_rdy pulsing in the same cycle as wr_req → count stays 2; pointers wrap correctly over 3 full rotations, with the data sequence 0..11 intact.
- Hazard:
  - Enqueue addr 0x100 and 0x200 with rd_addr=0x200 → rd_hazard=1 until the 0x200 entry's rdy pulse, then 0.
  - rd_addr=0x104 → rd_hazard=0 throughout.
- Async reset mid-drain: assert rst while in BUSY with count=3 (between clock edges) → sram_de=0 and count=0 immediately; no further SRAM requests after release.
